decoder_rr_arbiter: RTL

- Round-robin arbiter that shares the 2-to-4 decoder output lines between four requesters.
- Maintains the decoder's select (A) and enable (E) internally.
- Produces a registered one-hot grant vector.
- Sits between four bus masters and a shared resource whose select lines are decoder-driven; enforces a bounded tenure per grant.

---
 rtl/decoder_rr_arbiter.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/decoder_rr_arbiter.sv
// decoder_rr_arbiter: round-robin arbiter for four requesters.
// It drives the select (sel) and enable (en) inputs of a shared 2-to-4 decoder
// and limits each grant to MAX_HOLD consecutive cycles. The outputs gnt, sel
// and en are registered.
// Optional feature macro: ARB_GNT_CNT_EN. When defined, it adds the 16-bit
// gnt_cnt output, which counts issued grants.
module decoder_rr_arbiter #(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] sel,
  output logic       en,
  output logic       busy
`ifdef ARB_GNT_CNT_EN
  ,
  output logic [15:0] gnt_cnt
`endif
);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  state_t           state;
  logic [1:0]       ptr;
  logic [CNT_W-1:0] hold_cnt;

  state_t           nxt_state;
  logic [1:0]       nxt_sel;
  logic             nxt_en;
  logic [1:0]       nxt_ptr;
  logic [CNT_W-1:0] nxt_hold;
  logic             grant_evt;

  logic [2:0]       idle_pick;
  logic [2:0]       rel_pick;
  logic             hold_last;
  logic             release_now;

  // One-hot decode of the 2-bit select, as the shared decoder would produce.
  function automatic logic [3:0] dec2to4(input logic [1:0] a);
    logic [3:0] d;
    d = 4'b0000;
    d[a] = 1'b1;
    return d;
  endfunction

  // Round-robin search: base+1, base+2, base+3, then base itself when
  // incl_base is set. Returns {found, index}.
  function automatic logic [2:0] rr_pick(input logic [3:0] r,
                                         input logic [1:0] base,
                                         input logic       incl_base);
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    if (incl_base && r[base]) res = {1'b1, base};
    for (int i = 3; i >= 1; i--) begin
      idx = base + 2'(i);
      if (r[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  assign busy        = en;
  assign hold_last   = (hold_cnt == CNT_W'(MAX_HOLD - 1));
  assign release_now = !req[sel] || hold_last;
  assign idle_pick   = rr_pick(req, ptr, 1'b1);
  assign rel_pick    = rr_pick(req, sel, 1'b0);

  // Next-state decision. On a release the arbiter grants the next requester
  // in the same edge, so there is no idle cycle between grants.
  always_comb begin
    nxt_state = state;
    nxt_sel   = sel;
    nxt_en    = en;
    nxt_ptr   = ptr;
    nxt_hold  = hold_cnt;
    grant_evt = 1'b0;
    case (state)
      IDLE: begin
        if (idle_pick[2]) begin
          nxt_state = GRANT;
          nxt_sel   = idle_pick[1:0];
          nxt_en    = 1'b1;
          nxt_hold  = '0;
          grant_evt = 1'b1;
        end
      end
      GRANT: begin
        if (release_now) begin
          nxt_ptr = sel;
          if (rel_pick[2]) begin
            nxt_sel   = rel_pick[1:0];
            nxt_hold  = '0;
            grant_evt = 1'b1;
          end else if (req[sel]) begin
            // The tenure expired and no other requester is waiting, so the
            // same requester is granted again.
            nxt_hold  = '0;
            grant_evt = 1'b1;
          end else begin
            nxt_state = IDLE;
            nxt_en    = 1'b0;
            nxt_hold  = '0;
          end
        end else begin
          nxt_hold = hold_cnt + CNT_W'(1);
        end
      end
      default: begin
        nxt_state = IDLE;
        nxt_en    = 1'b0;
      end
    endcase
  end

  // Arbiter state and registered decoder outputs.
  // gnt is registered from the same next values as sel and en.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      sel      <= 2'b00;
      en       <= 1'b0;
      gnt      <= 4'b0000;
      ptr      <= 2'b11;
      hold_cnt <= '0;
    end else begin
      state    <= nxt_state;
      sel      <= nxt_sel;
      en       <= nxt_en;
      gnt      <= nxt_en ? dec2to4(nxt_sel) : 4'b0000;
      ptr      <= nxt_ptr;
      hold_cnt <= nxt_hold;
    end
  end

`ifdef ARB_GNT_CNT_EN
  // Counts issued grants, including re-grants after expiry.
  // The counter wraps at 16 bits.
  always_ff @(posedge clk) begin
    if (!rst_n) gnt_cnt <= 16'h0000;
    else if (grant_evt) gnt_cnt <= gnt_cnt + 16'h0001;
  end
`endif

endmodule
